ltl_violation_collector: RTL and testbench
==========================================

# ltl_violation_collector

Downstream consumer of a cluster's LTL monitor outputs: takes the per-property violation flags produced by the automata cluster and turns them into timestamped, software-readable violation records. Keeps sticky per-property status, saturating per-property counts and a 4-deep event FIFO. Drives a level interrupt toward the core's debug/CSR logic.

## Interface
- NUM_PROPS, 10, number of LTL property flags per cluster
- CNT_W, 8, width of each per-property saturating counter
- TS_W, 32, timestamp width
- FIFO_DEPTH, 4, event FIFO entries (power of two)

- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- run  in  1  monitoring enable; same signal that drives the cluster
- ltl_in  in  NUM_PROPS  violation flags from the cluster (bit i = ltl<i>c2)
- clr  in  1  one-cycle pulse; clears sticky, counters, overflow
- evt_valid  out  1  FIFO non-empty
- evt_ready  in  1  consumer accepts head record
- evt_ts  out  TS_W  timestamp of head record
- evt_vec  out  NUM_PROPS  properties newly violated in head record
- sticky  out  NUM_PROPS  accumulated violated properties
- overflow  out  1  a record was dropped on a full FIFO
- cnt_sel  in  4  property index for counter read
- cnt_out  out  CNT_W  counter[cnt_sel]; 0 if cnt_sel >= NUM_PROPS
- irq  out  1  registered OR of sticky and overflow

## Operation
- Timestamp counter increments every cycle run=1, holds when run=0, wraps modulo 2^TS_W.
- ltl_q registers ltl_in every cycle regardless of run. new = ltl_in & ~ltl_q (rising edges only; a flag held high counts once).
- Event cycle: run=1 and new != 0. Effects at that clock edge:
  - sticky |= new; counter[i] += 1 for each set bit of new, saturating at 2^CNT_W-1.
  - Push {ts, new} to FIFO. If FIFO full and no pop this cycle: drop record, set overflow.
- new is ignored entirely while run=0 (no sticky, count or push).
- Pop when evt_valid && evt_ready. Push and pop in the same cycle are both performed, including when full (no drop) and when empty (record passes through; evt_valid stays 1 next cycle).
- clr: sticky, counters, overflow go to 0. Clr and an event in the same cycle: clear first, then event applies (sticky = new, counter = 1 for new bits). FIFO and timestamp are not affected by clr.
- FIFO pointer state: empty, partial, full, derived from rd/wr pointers with extra wrap bit.

## Timing
- All outputs registered except cnt_out (combinational mux of counter registers).
- ltl_in rising in cycle N (run=1): evt_valid, sticky, counter and irq reflect it in cycle N+1; recorded evt_ts equals the timestamp value visible in cycle N.
- evt_ts/evt_vec show head record whenever evt_valid=1; stable until popped.
- Reset (asynchronous assertion, any time, including mid-push): timestamp, ltl_q, FIFO pointers, sticky, counters, overflow, irq all 0; evt_valid=0. Flags already high at reset release produce an event on the first run=1 cycle only if they were low in the previous sampled cycle; since ltl_q resets to 0, a flag high at release counts as a rising edge.

## Structure
- Package ltl_mon_pkg: NUM_PROPS, TS_W defaults and the event record struct {ts, vec}, shared with other clusters' collectors.
- Sub-module ltl_evt_fifo: parameterised synchronous FIFO with push/pop, full/empty, simultaneous push/pop on full; collector holds edge detect, timestamp, sticky, counters, irq.

## Test plan
- Reset, run=1, raise ltl_in[3] at ts=5 and hold 10 cycles -> one record {ts=5, vec=0x008}; sticky=0x008; cnt_sel=3 gives 1; irq=1 from next cycle.
- Bits 0 and 9 rise together at ts=7 -> single record vec=0x201; counters 0 and 9 each = 1.
- evt_ready=0, five distinct edge events -> four records kept in order, fifth dropped, overflow=1; then evt_ready=1 with a sixth edge on the full cycle -> pop and push both occur, no new drop.
- Toggle ltl_in[1] 300 times -> counter[1] saturates at 255; clr in the same cycle as a further edge -> counter[1]=1, sticky=0x002, overflow=0.
- run=0 with ltl_in edges -> no records, sticky unchanged, timestamp frozen; assert reset while evt_valid=1 -> all outputs 0 immediately, FIFO empty after release.

Source files
------------

// File: rtl/ltl_mon_pkg.sv
// Shared constants and record types for LTL cluster violation collectors.
// Other clusters' collectors import the same record layout.
package ltl_mon_pkg;

    localparam int NUM_PROPS  = 10;
    localparam int CNT_W      = 8;
    localparam int TS_W       = 32;
    localparam int FIFO_DEPTH = 4;

    typedef struct packed {
        logic [TS_W-1:0]      ts;
        logic [NUM_PROPS-1:0] vec;
    } evt_rec_t;

    typedef enum logic [1:0] {
        FIFO_EMPTY,
        FIFO_PARTIAL,
        FIFO_FULL
    } fifo_state_e;

endpackage

// File: rtl/ltl_evt_fifo.sv
// Synchronous event FIFO with wrap-bit pointers.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module ltl_evt_fifo
    import ltl_mon_pkg::*;
#(
    parameter int WIDTH = 42,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      rd_ptr;
    logic [AW:0]      wr_ptr;
    fifo_state_e      state;
    logic             do_push;
    logic             do_pop;

    // Equal pointers mean empty; same index with opposite wrap bit means full.
    always_comb begin
        state = FIFO_PARTIAL;
        if (rd_ptr == wr_ptr) begin
            state = FIFO_EMPTY;
        end else if (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]) begin
            state = FIFO_FULL;
        end
    end

    assign empty   = (state == FIFO_EMPTY);
    assign full    = (state == FIFO_FULL);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/ltl_violation_collector.sv
// Turns per-property LTL violation flags into timestamped records, sticky status,
// saturating per-property counts and a level interrupt.
module ltl_violation_collector #(
    parameter int NUM_PROPS  = ltl_mon_pkg::NUM_PROPS,
    parameter int CNT_W      = ltl_mon_pkg::CNT_W,
    parameter int TS_W       = ltl_mon_pkg::TS_W,
    parameter int FIFO_DEPTH = ltl_mon_pkg::FIFO_DEPTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic [NUM_PROPS-1:0] ltl_in,
    input  logic                 clr,
    output logic                 evt_valid,
    input  logic                 evt_ready,
    output logic [TS_W-1:0]      evt_ts,
    output logic [NUM_PROPS-1:0] evt_vec,
    output logic [NUM_PROPS-1:0] sticky,
    output logic                 overflow,
    input  logic [3:0]           cnt_sel,
    output logic [CNT_W-1:0]     cnt_out,
    output logic                 irq
);

    localparam int              REC_W   = TS_W + NUM_PROPS;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [TS_W-1:0]      ts;
    logic [NUM_PROPS-1:0] ltl_q;
    logic [NUM_PROPS-1:0] new_flags;
    logic [NUM_PROPS-1:0] sticky_d;
    logic                 overflow_d;
    logic [CNT_W-1:0]     cnt_q [NUM_PROPS];
    logic [CNT_W-1:0]     cnt_d [NUM_PROPS];
    logic                 event_hit;
    logic                 pop;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic [REC_W-1:0]     head;

    assign new_flags = ltl_in & ~ltl_q;
    assign event_hit = run && (new_flags != '0);
    assign pop       = evt_ready && !fifo_empty;
    assign evt_valid = !fifo_empty;
    assign {evt_ts, evt_vec} = head;

    ltl_evt_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (event_hit),
        .pop   (pop),
        .wdata ({ts, new_flags}),
        .rdata (head),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // Clear is applied first so an event in the same cycle lands on zeroed state.
    always_comb begin
        sticky_d   = clr ? '0 : sticky;
        overflow_d = clr ? 1'b0 : overflow;
        for (int i = 0; i < NUM_PROPS; i++) begin
            cnt_d[i] = clr ? '0 : cnt_q[i];
        end
        if (event_hit) begin
            sticky_d = sticky_d | new_flags;
            if (fifo_full && !pop) begin
                overflow_d = 1'b1;
            end
            for (int i = 0; i < NUM_PROPS; i++) begin
                if (new_flags[i] && (cnt_d[i] != CNT_MAX)) begin
                    cnt_d[i] = cnt_d[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts       <= '0;
            ltl_q    <= '0;
            sticky   <= '0;
            overflow <= 1'b0;
            irq      <= 1'b0;
            for (int i = 0; i < NUM_PROPS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            ltl_q    <= ltl_in;
            sticky   <= sticky_d;
            overflow <= overflow_d;
            irq      <= (sticky_d != '0) || overflow_d;
            if (run) begin
                ts <= ts + TS_W'(1);
            end
            for (int i = 0; i < NUM_PROPS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        cnt_out = '0;
        for (int i = 0; i < NUM_PROPS; i++) begin
            if (cnt_sel == 4'(i)) begin
                cnt_out = cnt_q[i];
            end
        end
    end

endmodule

// File: tb/tb_ltl_violation_collector.sv
// Directed scenarios plus randomised traffic for ltl_violation_collector, checked
// every cycle against a queue-based reference model.
module tb_ltl_violation_collector;
    import ltl_mon_pkg::*;

    localparam int NP      = NUM_PROPS;
    localparam int CNT_TOP = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             run = 1'b0;
    logic [NP-1:0]    ltl_in = '0;
    logic             clr = 1'b0;
    logic             evt_ready = 1'b0;
    logic [3:0]       cnt_sel = '0;
    logic             evt_valid;
    logic [TS_W-1:0]  evt_ts;
    logic [NP-1:0]    evt_vec;
    logic [NP-1:0]    sticky;
    logic             overflow;
    logic [CNT_W-1:0] cnt_out;
    logic             irq;

    ltl_violation_collector dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .ltl_in    (ltl_in),
        .clr       (clr),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_ts    (evt_ts),
        .evt_vec   (evt_vec),
        .sticky    (sticky),
        .overflow  (overflow),
        .cnt_sel   (cnt_sel),
        .cnt_out   (cnt_out),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    evt_rec_t        mq[$];
    logic [TS_W-1:0] m_ts;
    logic [NP-1:0]   m_prev;
    logic [NP-1:0]   m_sticky;
    bit              m_ovf;
    int              m_cnt[NP];
    logic [NP-1:0]   rnd_ltl;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        mq.delete();
        m_ts     = '0;
        m_prev   = '0;
        m_sticky = '0;
        m_ovf    = 1'b0;
        for (int i = 0; i < NP; i++) m_cnt[i] = 0;
    endtask

    // What the collector should hold after the next clock edge, given these inputs.
    task automatic modelStep(input bit r, input logic [NP-1:0] l, input bit rdy, input bit c);
        logic [NP-1:0] nw;
        bit hit;
        bit popped;
        nw     = l & ~m_prev;
        hit    = r && (nw != '0);
        popped = rdy && (mq.size() > 0);
        m_prev = l;
        if (c) begin
            m_sticky = '0;
            m_ovf    = 1'b0;
            for (int i = 0; i < NP; i++) m_cnt[i] = 0;
        end
        if (hit) begin
            m_sticky = m_sticky | nw;
            for (int i = 0; i < NP; i++) begin
                if (nw[i]) m_cnt[i] = (m_cnt[i] >= CNT_TOP) ? CNT_TOP : m_cnt[i] + 1;
            end
        end
        if (popped) void'(mq.pop_front());
        if (hit) begin
            if (mq.size() < FIFO_DEPTH) mq.push_back('{ts: m_ts, vec: nw});
            else m_ovf = 1'b1;
        end
        if (r) m_ts = m_ts + 1'b1;
    endtask

    task automatic checkAll();
        int s;
        s = int'(cnt_sel);
        checkOutput("evt_valid", 64'(evt_valid), 64'(mq.size() != 0));
        if (mq.size() != 0) begin
            checkOutput("evt_ts", 64'(evt_ts), 64'(mq[0].ts));
            checkOutput("evt_vec", 64'(evt_vec), 64'(mq[0].vec));
        end else begin
            checkOutput("evt_ts_idle", 64'(evt_ts), 64'(0));
            checkOutput("evt_vec_idle", 64'(evt_vec), 64'(0));
        end
        checkOutput("sticky", 64'(sticky), 64'(m_sticky));
        checkOutput("overflow", 64'(overflow), 64'(m_ovf));
        checkOutput("irq", 64'(irq), 64'((m_sticky != '0) || m_ovf));
        checkOutput("cnt_out", 64'(cnt_out), (s < NP) ? 64'(m_cnt[s]) : 64'(0));
    endtask

    // Check the state left by the previous edge, then drive inputs for the next one.
    task automatic applyStimulus(input bit r, input logic [NP-1:0] l, input bit rdy,
                                 input bit c, input int sel);
        @(negedge clk);
        checkAll();
        run       = r;
        ltl_in    = l;
        evt_ready = rdy;
        clr       = c;
        cnt_sel   = 4'(sel);
        modelStep(r, l, rdy, c);
    endtask

    // Asserts reset between edges, so whatever edge was pending never happens.
    task automatic doReset();
        #2 reset = 1'b0;
        #1;
        checkOutput("rst_valid", 64'(evt_valid), 64'(0));
        checkOutput("rst_ts", 64'(evt_ts), 64'(0));
        checkOutput("rst_vec", 64'(evt_vec), 64'(0));
        checkOutput("rst_sticky", 64'(sticky), 64'(0));
        checkOutput("rst_overflow", 64'(overflow), 64'(0));
        checkOutput("rst_irq", 64'(irq), 64'(0));
        checkOutput("rst_cnt", 64'(cnt_out), 64'(0));
        run       = 1'b0;
        ltl_in    = '0;
        evt_ready = 1'b0;
        clr       = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        modelReset();
    endtask

    initial begin
        modelReset();
        doReset();

        // Single held flag gives exactly one record.
        repeat (5) applyStimulus(1, '0, 0, 0, 3);
        applyStimulus(1, NP'(10'h008), 0, 0, 3);
        repeat (10) applyStimulus(1, NP'(10'h008), 0, 0, 3);
        #1;
        checkOutput("s1_ts", 64'(evt_ts), 64'(5));
        checkOutput("s1_vec", 64'(evt_vec), 64'(10'h008));
        checkOutput("s1_sticky", 64'(sticky), 64'(10'h008));
        checkOutput("s1_cnt3", 64'(cnt_out), 64'(1));
        checkOutput("s1_irq", 64'(irq), 64'(1));
        applyStimulus(1, NP'(10'h008), 1, 0, 3);
        applyStimulus(1, NP'(10'h008), 0, 0, 3);
        #1 checkOutput("s1_single", 64'(evt_valid), 64'(0));

        // Two flags rising together share one record.
        doReset();
        repeat (7) applyStimulus(1, '0, 0, 0, 0);
        applyStimulus(1, NP'(10'h201), 0, 0, 0);
        applyStimulus(1, NP'(10'h201), 0, 0, 0);
        #1;
        checkOutput("s2_ts", 64'(evt_ts), 64'(7));
        checkOutput("s2_vec", 64'(evt_vec), 64'(10'h201));
        checkOutput("s2_cnt0", 64'(cnt_out), 64'(1));
        applyStimulus(1, NP'(10'h201), 0, 0, 9);
        #1 checkOutput("s2_cnt9", 64'(cnt_out), 64'(1));

        // Fill, overflow, then simultaneous push and pop on a full FIFO.
        doReset();
        applyStimulus(1, '0, 0, 0, 0);
        for (int k = 0; k < 5; k++) applyStimulus(1, NP'(1) << k, 0, 0, k);
        applyStimulus(1, NP'(10'h020), 1, 0, 5);
        #1;
        checkOutput("s3_ovf", 64'(overflow), 64'(1));
        checkOutput("s3_head", 64'(evt_vec), 64'(10'h001));
        applyStimulus(1, '0, 1, 0, 0);
        #1 checkOutput("s3_next", 64'(evt_vec), 64'(10'h002));
        repeat (5) applyStimulus(1, '0, 1, 0, 0);

        // Counter saturation, then clear coinciding with a new edge.
        doReset();
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1, '0, 0, 0, 1);
            applyStimulus(1, NP'(10'h002), 0, 0, 1);
        end
        applyStimulus(1, '0, 0, 0, 1);
        #1;
        checkOutput("s4_sat", 64'(cnt_out), 64'(CNT_TOP));
        checkOutput("s4_ovf", 64'(overflow), 64'(1));
        repeat (5) applyStimulus(1, '0, 1, 0, 1);
        applyStimulus(1, NP'(10'h002), 0, 1, 1);
        applyStimulus(1, NP'(10'h002), 0, 0, 1);
        #1;
        checkOutput("s4_cnt1", 64'(cnt_out), 64'(1));
        checkOutput("s4_sticky", 64'(sticky), 64'(10'h002));
        checkOutput("s4_ovf_clr", 64'(overflow), 64'(0));

        // Edges ignored while stopped; timestamp frozen; reset with a record pending.
        doReset();
        repeat (3) applyStimulus(1, '0, 0, 0, 2);
        applyStimulus(1, NP'(10'h004), 0, 0, 2);
        applyStimulus(1, NP'(10'h004), 0, 0, 2);
        for (int j = 0; j < 6; j++) applyStimulus(0, (j % 2 == 0) ? NP'(10'h3F0) : '0, 0, 0, 2);
        #1;
        checkOutput("s5_sticky", 64'(sticky), 64'(10'h004));
        applyStimulus(1, NP'(10'h001), 1, 0, 2);
        applyStimulus(1, NP'(10'h001), 0, 0, 2);
        #1;
        checkOutput("s5_ts", 64'(evt_ts), 64'(5));
        checkOutput("s5_vec", 64'(evt_vec), 64'(10'h001));
        applyStimulus(1, NP'(10'h003), 0, 0, 2);
        doReset();
        applyStimulus(1, '0, 0, 0, 0);
        #1 checkOutput("s5_empty", 64'(evt_valid), 64'(0));

        // Random traffic with occasional clears and resets.
        doReset();
        rnd_ltl = '0;
        for (int n = 0; n < 600; n++) begin
            rnd_ltl = rnd_ltl ^ (NP'($urandom) & NP'($urandom));
            applyStimulus($urandom_range(0, 3) != 0, rnd_ltl, $urandom_range(0, 2) != 0,
                          $urandom_range(0, 19) == 0, int'($urandom_range(0, 15)));
            if ($urandom_range(0, 199) == 0) begin
                doReset();
                rnd_ltl = '0;
            end
        end
        applyStimulus(0, '0, 0, 0, 0);
        @(negedge clk);
        checkAll();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
